// File: rtl/seq_monitor_pkg.sv
// rtl/seq_monitor_pkg.sv - shared types, symbol map and constants for seq_monitor
package seq_monitor_pkg;

  localparam int SEQ_LEN = 4;
  localparam int IDX_W   = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_BAD  = 2'd3
  } step_t;

  // Observed {FA,FB} symbols in forward order
  localparam logic [1:0] SYM_0 = 2'b00;
  localparam logic [1:0] SYM_1 = 2'b11;
  localparam logic [1:0] SYM_2 = 2'b01;
  localparam logic [1:0] SYM_3 = 2'b10;

  function automatic logic [IDX_W-1:0] sym_to_idx(input logic [1:0] sym);
    logic [IDX_W-1:0] idx;
    case (sym)
      SYM_0:   idx = 2'd0;
      SYM_1:   idx = 2'd1;
      SYM_2:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seq_step_classify.sv
// rtl/seq_step_classify.sv - classifies one symbol transition as hold/fwd/rev/bad
module seq_step_classify
  import seq_monitor_pkg::*;
(
  input  logic [1:0]       prev_sym,
  input  logic [1:0]       new_sym,
  output step_t            step,
  output logic [IDX_W-1:0] new_idx
);

  logic [IDX_W-1:0] prev_idx;
  logic [IDX_W-1:0] delta;

  always_comb begin
    new_idx  = sym_to_idx(new_sym);
    prev_idx = sym_to_idx(prev_sym);
    // Index width equals log2(SEQ_LEN), so subtraction wraps modulo the sequence length
    delta    = new_idx - prev_idx;
    case (delta)
      2'd0:    step = STEP_HOLD;
      2'd1:    step = STEP_FWD;
      2'd3:    step = STEP_REV;
      default: step = STEP_BAD;
    endcase
  end

endmodule

// File: rtl/seq_monitor.sv
// rtl/seq_monitor.sv - tracks a 4-state symbol sequence, locks on direction, counts errors
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned UNLOCK_ERRS = 2
) (
  input  logic             t_clock,
  input  logic             t_reset,
  input  logic             in_valid,
  input  logic [1:0]       in_state,
  output logic             locked,
  output logic             dir,
  output logic [IDX_W-1:0] position,
  output logic             err_pulse,
  output logic [7:0]       err_count
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  state_t           state, state_nxt;
  logic [1:0]       ref_sym, ref_nxt;
  logic [IDX_W-1:0] pos_nxt;
  logic             dir_nxt, locked_nxt, pulse_nxt;
  logic             cand_dir, cand_dir_nxt, cand_vld, cand_vld_nxt;
  logic [3:0]       good_cnt, good_nxt, bad_cnt, bad_nxt;
  logic [7:0]       err_cnt_nxt;
  step_t            step;
  logic [IDX_W-1:0] new_idx;
  logic             step_dir;

  seq_step_classify u_classify (
    .prev_sym (ref_sym),
    .new_sym  (in_state),
    .step     (step),
    .new_idx  (new_idx)
  );

  always_ff @(posedge t_clock or posedge t_reset) begin
    if (t_reset) begin
      state     <= ST_IDLE;
      ref_sym   <= 2'b00;
      position  <= '0;
      dir       <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
      cand_dir  <= 1'b0;
      cand_vld  <= 1'b0;
      good_cnt  <= 4'd0;
      bad_cnt   <= 4'd0;
    end else begin
      state     <= state_nxt;
      ref_sym   <= ref_nxt;
      position  <= pos_nxt;
      dir       <= dir_nxt;
      locked    <= locked_nxt;
      err_pulse <= pulse_nxt;
      err_count <= err_cnt_nxt;
      cand_dir  <= cand_dir_nxt;
      cand_vld  <= cand_vld_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ref_nxt      = ref_sym;
    pos_nxt      = position;
    dir_nxt      = dir;
    locked_nxt   = locked;
    pulse_nxt    = 1'b0;
    err_cnt_nxt  = err_count;
    cand_dir_nxt = cand_dir;
    cand_vld_nxt = cand_vld;
    good_nxt     = good_cnt;
    bad_nxt      = bad_cnt;
    step_dir     = (step == STEP_REV);

    if (in_valid) begin
      // Every sample re-anchors, so a bad step is judged only once
      ref_nxt = in_state;
      pos_nxt = new_idx;
      case (state)
        ST_IDLE: begin
          state_nxt    = ST_SYNC;
          good_nxt     = 4'd0;
          cand_vld_nxt = 1'b0;
          cand_dir_nxt = 1'b0;
        end
        ST_SYNC: begin
          if (step == STEP_FWD || step == STEP_REV) begin
            if (cand_vld && step_dir == cand_dir) begin
              good_nxt = good_cnt + 4'd1;
            end else begin
              cand_dir_nxt = step_dir;
              cand_vld_nxt = 1'b1;
              good_nxt     = 4'd1;
            end
            if (good_nxt == LOCK_N) begin
              state_nxt  = ST_LOCKED;
              locked_nxt = 1'b1;
              dir_nxt    = cand_dir_nxt;
              bad_nxt    = 4'd0;
            end
          end else if (step == STEP_BAD) begin
            good_nxt     = 4'd0;
            cand_vld_nxt = 1'b0;
            cand_dir_nxt = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (step != STEP_HOLD) begin
            if (step != STEP_BAD && step_dir == dir) begin
              bad_nxt = 4'd0;
            end else begin
              pulse_nxt   = 1'b1;
              err_cnt_nxt = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
              bad_nxt     = bad_cnt + 4'd1;
              // dir is kept so software can see the last locked direction
              if (bad_nxt == UNLOCK_N) begin
                state_nxt    = ST_SYNC;
                locked_nxt   = 1'b0;
                good_nxt     = 4'd0;
                bad_nxt      = 4'd0;
                cand_vld_nxt = 1'b0;
                cand_dir_nxt = 1'b0;
              end
            end
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          locked_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 LOCK_COUNT, default 3, consecutive in-direction steps required to lock (legal 1..15).
REQ-002 UNLOCK_ERRS, default 2, consecutive bad steps while locked that drop lock (legal 1..15).
REQ-003 t_clock  input  1  clock; all state updates on rising edge.
REQ-004 t_reset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  in_state is sampled on this edge.
REQ-006 in_state  input  2  observed {FA,FB} symbol from the 4-state sequence generator.
REQ-007 locked  output  1  sequence tracked and stable.
REQ-008 dir  output  1  0 = forward (00->11->01->10->00), 1 = reverse.
REQ-009 position  output  2  index of last sampled symbol.
REQ-010 err_pulse  output  1  one-cycle pulse per bad step while locked.
REQ-011 err_count  output  8  saturating count of locked-state errors.

Function
REQ-012 Symbol index map SHALL be 00->0, 11->1, 01->2, 10->3; delta = (idx_new - idx_prev) mod 4.
REQ-013 Step class SHALL be: delta 0 = hold, delta 1 = fwd, delta 3 = rev, delta 2 = bad.
REQ-014 FSM states SHALL be IDLE, SYNC, LOCKED.
REQ-015 IDLE: first in_valid sample stored as reference, position updated, -> SYNC with good_cnt=0, candidate direction unset.
REQ-016 SYNC: first fwd/rev step sets candidate dir, good_cnt=1; each further step matching candidate increments good_cnt.
REQ-017 SYNC: step opposite to candidate SHALL flip candidate and set good_cnt=1; bad step SHALL clear good_cnt and candidate.
REQ-018 SYNC -> LOCKED on the edge good_cnt reaches LOCK_COUNT; locked=1 and dir=candidate from that edge.
REQ-019 SYNC SHALL never assert err_pulse or change err_count.
REQ-020 LOCKED: step equal to dir SHALL clear bad_cnt; opposite or bad step SHALL assert err_pulse, increment err_count (saturate 255), increment bad_cnt.
REQ-021 LOCKED -> SYNC when bad_cnt reaches UNLOCK_ERRS: locked=0 on same edge, good_cnt=0, candidate cleared, dir retains last value.
REQ-022 Hold steps SHALL change no counter, state or output in any FSM state.
REQ-023 Reference symbol and position SHALL update on every in_valid sample, including bad steps (re-anchor).
REQ-024 in_valid low SHALL leave all state unchanged and err_pulse=0.
REQ-025 All outputs SHALL be registered; effect of a sample visible the cycle after its capturing edge.
REQ-026 err_count SHALL NOT clear on unlock; only reset clears it.

Reset
REQ-027 t_reset SHALL immediately force FSM=IDLE, locked=0, dir=0, position=0, err_pulse=0, err_count=0, all internal counters 0.
REQ-028 Reset asserted mid-stream SHALL discard history; first in_valid sample after release is the new reference.

Structure
REQ-029 Package seq_monitor_pkg SHALL hold FSM state enum, symbol-to-index constants, SEQ_LEN=4 and step-class enum.
REQ-030 Combinational sub-module seq_step_classify (prev symbol, new symbol -> hold/fwd/rev/bad, new index) SHALL be instantiated once; all registers live in seq_monitor.

Verification
REQ-031 Reset, feed 00,11,01,10 one valid cycle each -> locked=1 after 4th sample, dir=0, position=3, err_count=0.
REQ-032 Reset, feed 00,10,01,11 -> locked=1 after 4th sample, dir=1, position=1.
REQ-033 Locked forward at 10, feed 11 -> one err_pulse, err_count=1, locked=1; then feed 10 -> err_count=2, locked=0.
REQ-034 Locked forward, feed 11 five consecutive cycles then 01 -> no err_pulse, locked stays 1, position=2.
REQ-035 Repeat (3 good steps, 2 bad steps) 130 times -> err_count reaches 255 and stays 255.
REQ-036 Assert t_reset between clock edges while locked -> all outputs 0 before next edge; after release feed 01,10,00,11 -> relocks with dir=0.
